// File: rtl/flash_mp_region_chk.sv
// flash_mp_region_chk: two-stage memory-protection check of flash page accesses
// against NumRegions region configs with default fallback and a saturating deny count.
`default_nettype none

module flash_mp_region_chk #(
  parameter int NumRegions = 8,
  parameter int AddrW      = 16,
  parameter int IdxW       = (NumRegions > 1) ? $clog2(NumRegions) : 1,
  parameter int CntW       = 8,
  localparam int CfgW      = 5 + AddrW + AddrW + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumRegions-1:0][CfgW-1:0]  region_cfg_i,
  input  logic [3:0]                       default_cfg_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [AddrW-1:0]                 req_addr_i,
  input  logic [1:0]                       req_op_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic                             rsp_allow_o,
  output logic                             rsp_he_o,
  output logic                             rsp_hit_o,
  output logic [IdxW-1:0]                  rsp_idx_o,
  input  logic                             deny_cnt_clr_i,
  output logic [CntW-1:0]                  deny_cnt_o
);

  logic             s1_valid_q, s1_valid_d;
  logic [AddrW-1:0] s1_addr_q;
  logic [1:0]       s1_op_q;

  logic             rsp_valid_q;
  logic             rsp_allow_q;
  logic             rsp_he_q;
  logic             rsp_hit_q;
  logic [IdxW-1:0]  rsp_idx_q;
  logic [CntW-1:0]  deny_cnt_q, deny_cnt_d;

  logic             s2_load;
  logic             req_accept;

  logic [NumRegions-1:0] match;
  logic                  lk_hit;
  logic [IdxW-1:0]       lk_idx;
  logic [3:0]            lk_perm;
  logic                  lk_allow;

  assign s2_load     = s1_valid_q & (~rsp_valid_q | rsp_ready_i);
  assign req_ready_o = ~s1_valid_q | s2_load;
  assign req_accept  = req_valid_i & req_ready_o;
  assign s1_valid_d  = req_accept | (s1_valid_q & ~s2_load);

  // Limit is formed one bit wider so a region ending at the top of the space never wraps.
  for (genvar g = 0; g < NumRegions; g++) begin : g_match
    logic [AddrW-1:0] base;
    logic [AddrW:0]   size;
    logic [AddrW:0]   limit;
    assign base     = region_cfg_i[g][2*AddrW:AddrW+1];
    assign size     = region_cfg_i[g][AddrW:0];
    assign limit    = {1'b0, base} + size;
    assign match[g] = region_cfg_i[g][CfgW-1]
                    & (s1_addr_q >= base)
                    & ({1'b0, s1_addr_q} < limit);
  end

  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_perm = default_cfg_i;
    for (int i = NumRegions - 1; i >= 0; i--) begin
      if (match[i]) begin
        lk_hit  = 1'b1;
        lk_idx  = IdxW'(i);
        lk_perm = region_cfg_i[i][CfgW-2:CfgW-5];
      end
    end
  end

  always_comb begin
    case (s1_op_q)
      2'd0:    lk_allow = lk_perm[3];
      2'd1:    lk_allow = lk_perm[2];
      2'd2:    lk_allow = lk_perm[1];
      default: lk_allow = 1'b0;
    endcase
  end

  always_comb begin
    deny_cnt_d = deny_cnt_q;
    if (deny_cnt_clr_i) begin
      deny_cnt_d = '0;
    end else if (s2_load && !lk_allow && !(&deny_cnt_q)) begin
      deny_cnt_d = deny_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_op_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_allow_q <= 1'b0;
      rsp_he_q    <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      deny_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (req_accept) begin
        s1_addr_q <= req_addr_i;
        s1_op_q   <= req_op_i;
      end
      if (s2_load) begin
        rsp_valid_q <= 1'b1;
        rsp_allow_q <= lk_allow;
        rsp_he_q    <= lk_perm[0];
        rsp_hit_q   <= lk_hit;
        rsp_idx_q   <= lk_idx;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
      deny_cnt_q <= deny_cnt_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_allow_o = rsp_allow_q;
  assign rsp_he_o    = rsp_he_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign deny_cnt_o  = deny_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_flash_mp_region_chk.sv
// Bench for flash_mp_region_chk: directed cases with literal expectations, then
// randomized traffic checked every cycle against a queue-level reference model.
`default_nettype none

module tb_flash_mp_region_chk;
  localparam int NR   = 8;
  localparam int AW   = 16;
  localparam int IW   = 3;
  localparam int CW   = 2;
  localparam int CFGW = 5 + AW + AW + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [NR-1:0][CFGW-1:0]  region_cfg;
  logic [3:0]               default_cfg = 4'd0;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  logic [AW-1:0]            req_addr = '0;
  logic [1:0]               req_op = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b1;
  logic                     rsp_allow, rsp_he, rsp_hit;
  logic [IW-1:0]            rsp_idx;
  logic                     deny_clr = 1'b0;
  logic [CW-1:0]            deny_cnt;

  logic        c_en[NR], c_rd[NR], c_pg[NR], c_er[NR], c_he[NR];
  logic [15:0] c_base[NR];
  logic [16:0] c_size[NR];

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int i = 0; i < NR; i++)
      region_cfg[i] = {c_en[i], c_rd[i], c_pg[i], c_er[i], c_he[i], c_base[i], c_size[i]};
  end

  flash_mp_region_chk #(.NumRegions(NR), .AddrW(AW), .IdxW(IW), .CntW(CW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .region_cfg_i   (region_cfg),
    .default_cfg_i  (default_cfg),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_op_i       (req_op),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_allow_o    (rsp_allow),
    .rsp_he_o       (rsp_he),
    .rsp_hit_o      (rsp_hit),
    .rsp_idx_o      (rsp_idx),
    .deny_cnt_clr_i (deny_clr),
    .deny_cnt_o     (deny_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decision: first enabled region containing the address, else default.
  function automatic void decide(input int addr, input int op,
                                 output logic allow, output logic he,
                                 output logic hit, output int idx);
    logic rd, pg, er;
    hit = 1'b0; idx = 0;
    rd = default_cfg[3]; pg = default_cfg[2]; er = default_cfg[1]; he = default_cfg[0];
    for (int i = 0; i < NR; i++) begin
      if (!hit && c_en[i] && addr >= int'(c_base[i]) && addr < int'(c_base[i]) + int'(c_size[i])) begin
        hit = 1'b1; idx = i;
        rd = c_rd[i]; pg = c_pg[i]; er = c_er[i]; he = c_he[i];
      end
    end
    allow = (op == 0) ? rd : (op == 1) ? pg : (op == 2) ? er : 1'b0;
  endfunction

  // Model: at most one request waiting for decision, at most one response on offer.
  logic m_s1_v = 1'b0, m_out_v = 1'b0;
  int   m_s1_addr, m_s1_op;
  logic m_allow, m_he, m_hit;
  int   m_idx, m_cnt;
  logic e_move, e_ready, n_allow, n_he, n_hit;
  int   n_idx;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_s1_v = 1'b0; m_out_v = 1'b0; m_cnt = 0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_fields", {28'd0, rsp_allow, rsp_he, rsp_hit, 1'b0} | 32'(rsp_idx), 32'd0);
      chk("rst_deny_cnt", 32'(deny_cnt), 32'd0);
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'(m_out_v));
      if (m_out_v) begin
        chk("rsp_allow", 32'(rsp_allow), 32'(m_allow));
        chk("rsp_he", 32'(rsp_he), 32'(m_he));
        chk("rsp_hit", 32'(rsp_hit), 32'(m_hit));
        chk("rsp_idx", 32'(rsp_idx), 32'(m_idx));
      end
      chk("deny_cnt", 32'(deny_cnt), 32'(m_cnt));
      e_move  = m_s1_v && (!m_out_v || rsp_ready);
      e_ready = !m_s1_v || e_move;
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      n_allow = 1'b1;
      if (e_move) decide(m_s1_addr, m_s1_op, n_allow, n_he, n_hit, n_idx);
      if (deny_clr) m_cnt = 0;
      else if (e_move && !n_allow && m_cnt < CMAX) m_cnt++;
      if (e_move) begin
        m_out_v = 1'b1; m_allow = n_allow; m_he = n_he; m_hit = n_hit; m_idx = n_idx;
      end else if (rsp_ready) begin
        m_out_v = 1'b0;
      end
      if (req_valid && e_ready) begin
        m_s1_v = 1'b1; m_s1_addr = int'(req_addr); m_s1_op = int'(req_op);
      end else if (e_move) begin
        m_s1_v = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clr_regions();
    for (int i = 0; i < NR; i++) begin
      c_en[i] = 0; c_rd[i] = 0; c_pg[i] = 0; c_er[i] = 0; c_he[i] = 0;
      c_base[i] = '0; c_size[i] = '0;
    end
  endtask

  task automatic set_reg(input int i, input logic en, input logic rd, input logic pg,
                         input logic er, input logic he, input int base, input int size);
    c_en[i] = en; c_rd[i] = rd; c_pg[i] = pg; c_er[i] = er; c_he[i] = he;
    c_base[i] = 16'(base); c_size[i] = 17'(size);
  endtask

  // Presents one request; returns one cycle after acceptance, when the response is on offer.
  task automatic send(input int addr, input int op);
    req_valid = 1'b1; req_addr = 16'(addr); req_op = 2'(op); rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  task automatic rand_region(input int i);
    int b, s;
    c_en[i] = ($urandom % 4) != 0;
    c_rd[i] = 1'($urandom); c_pg[i] = 1'($urandom); c_er[i] = 1'($urandom); c_he[i] = 1'($urandom);
    b = (($urandom % 4) == 0) ? 16'hFFC0 + int'($urandom % 64) : int'($urandom % 256);
    case ($urandom % 8)
      0:       s = 0;
      1:       s = 65536 - b;
      default: s = int'($urandom % 96);
    endcase
    c_base[i] = 16'(b); c_size[i] = 17'(s);
  endtask

  int addrs[4] = '{32'h0100, 32'h0200, 32'h0101, 32'h0300};
  int k, cyc;
  logic acc;

  initial begin
    clr_regions();
    repeat (3) tick();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_deny_cnt", 32'(deny_cnt), 32'd0);
    rst_ni = 1'b1;
    #1 chk("reset_req_ready", 32'(req_ready), 32'd1);
    tick();

    set_reg(0, 1, 1, 0, 0, 0, 'h0100, 'h10);
    send('h0105, 0);
    chk("basic_valid", 32'(rsp_valid), 32'd1);
    chk("basic_allow_hit_idx", {30'd0, rsp_allow, rsp_hit} | (32'(rsp_idx) << 2), 32'h3);
    tick();

    clr_regions();
    set_reg(2, 1, 1, 0, 1, 0, 'h0000, 'h1000);
    set_reg(5, 1, 1, 1, 1, 0, 'h0000, 'h1000);
    send('h0010, 1);
    chk("overlap_idx", 32'(rsp_idx), 32'd2);
    chk("overlap_allow", 32'(rsp_allow), 32'd0);
    chk("overlap_deny_cnt", 32'(deny_cnt), 32'd1);
    tick();

    clr_regions();
    set_reg(1, 1, 1, 0, 0, 0, 'hFFF0, 'h10);
    send('hFFFF, 0);
    chk("top_edge_hit", 32'(rsp_hit), 32'd1);
    chk("top_edge_idx", 32'(rsp_idx), 32'd1);
    tick();

    clr_regions();
    set_reg(0, 1, 1, 0, 0, 0, 'h0100, 'h10);
    send('h0110, 0);
    chk("limit_excl_hit", 32'(rsp_hit), 32'd0);
    tick();

    clr_regions();
    set_reg(3, 1, 1, 1, 1, 1, 'h0200, 0);
    send('h0200, 0);
    chk("size0_hit", 32'(rsp_hit), 32'd0);
    chk("deny_cnt_at_max", 32'(deny_cnt), 32'd3);
    tick();

    set_reg(0, 1, 1, 1, 1, 0, 'h0100, 'h10);
    send('h0105, 3);
    chk("op3_allow", 32'(rsp_allow), 32'd0);
    chk("op3_hit", 32'(rsp_hit), 32'd1);
    chk("deny_cnt_saturated", 32'(deny_cnt), 32'd3);
    tick();

    clr_regions();
    default_cfg = 4'b1001;
    send('h0040, 2);
    chk("default_fields", {28'd0, rsp_hit, rsp_allow, rsp_he, 1'b0} | 32'(rsp_idx), 32'h2);
    tick();

    // Clear arriving on the same edge as a denied response load wins.
    req_valid = 1'b1; req_addr = 16'h0000; req_op = 2'd3;
    tick();
    req_valid = 1'b0; deny_clr = 1'b1;
    tick();
    deny_clr = 1'b0;
    chk("clr_vs_inc_valid", 32'(rsp_valid), 32'd1);
    chk("clr_vs_inc_cnt", 32'(deny_cnt), 32'd0);
    tick();

    default_cfg = 4'd0;
    set_reg(0, 1, 1, 0, 0, 0, 'h0100, 'h10);
    rsp_ready = 1'b0;
    k = 0; cyc = 0;
    while (cyc < 5) begin
      req_valid = 1'b1; req_addr = 16'(addrs[k]); req_op = 2'd0;
      #1 acc = req_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    chk("bp_accepts", 32'(k), 32'd2);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_rsp_first_allow", {30'd0, rsp_valid, rsp_allow}, 32'h3);
    rsp_ready = 1'b1;
    cyc = 0;
    while (k < 4 && cyc < 20) begin
      req_valid = 1'b1; req_addr = 16'(addrs[k]);
      #1 acc = req_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    chk("bp_all_accepted", 32'(k), 32'd4);
    req_valid = 1'b0;
    repeat (4) tick();
    chk("bp_deny_cnt", 32'(deny_cnt), 32'd2);

    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 16'h0101;
    repeat (3) tick();
    req_valid = 1'b0;
    rst_ni = 1'b0;
    #1 chk("midrst_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst_ni = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < NR; i++) rand_region(i);
    for (int n = 0; n < 4000; n++) begin
      if (($urandom % 16) == 0) rand_region(int'($urandom % NR));
      if (($urandom % 64) == 0) default_cfg = 4'($urandom);
      req_valid = ($urandom % 4) != 0;
      req_addr  = (($urandom % 4) == 0) ? 16'hFF80 + 16'($urandom % 128) : 16'($urandom % 320);
      req_op    = 2'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      deny_clr  = ($urandom % 32) == 0;
      tick();
    end
    req_valid = 1'b0; deny_clr = 1'b0; rsp_ready = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
